apb_master_bridge: RTL and testbench

- APB initiator (requester side) for the GPIO subsystem.
- Accepts single-transfer commands from an on-chip controller over a valid/ready command port.
- Drives the APB SETUP/ACCESS sequence to a slave, honours pready wait states and pslverr, and returns read data and status on a valid/ready response port.
- One transfer in flight at a time; all APB outputs registered.

---
 rtl/apb_master_bridge_if.sv | 38 +++
 rtl/apb_master_bridge.sv | 163 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Command/response and APB bus bundle for apb_master_bridge.
// master modport is the bridge side; slave modport is the controller/APB-slave side.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: valid/ready command in, APB SETUP/ACCESS out, valid/ready response back.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 pclk,
    input  logic                 presetn,
    apb_master_bridge_if.master  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]        state_r,     state_s;
    logic              cmd_ready_r, cmd_ready_s;
    logic              psel_r,      psel_s;
    logic              penable_r,   penable_s;
    logic              pwrite_r,    pwrite_s;
    logic [ADDR_W-1:0] paddr_r,     paddr_s;
    logic [DATA_W-1:0] pwdata_r,    pwdata_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic              rsp_err_r,   rsp_err_s;
    logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_s;
    logic              timeout_hit_s;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_r;

    // Wait-state counter: zero outside ACCESS, so it is clear on every ACCESS entry.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r != ACCESS) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (!bus.pready) begin
            tmo_cnt_r <= tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Limit reached on this edge unless the slave answers in the same cycle.
    always_comb begin
        timeout_hit_s = (state_r == ACCESS) && !bus.pready && (tmo_cnt_r == TMO_LAST);
    end
`else
    // No timeout hardware: ACCESS waits for pready indefinitely.
    always_comb begin
        timeout_hit_s = 1'b0;
    end
`endif

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_s     = state_r;
        cmd_ready_s = cmd_ready_r;
        psel_s      = psel_r;
        penable_s   = penable_r;
        pwrite_s    = pwrite_r;
        paddr_s     = paddr_r;
        pwdata_s    = pwdata_r;
        rsp_valid_s = rsp_valid_r;
        rsp_err_s   = rsp_err_r;
        rsp_rdata_s = rsp_rdata_r;
        case (state_r)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_r) begin
                    pwrite_s    = bus.cmd_write;
                    paddr_s     = bus.cmd_addr;
                    pwdata_s    = bus.cmd_wdata;
                    psel_s      = 1'b1;
                    penable_s   = 1'b0;
                    cmd_ready_s = 1'b0;
                    state_s     = SETUP;
                end else begin
                    cmd_ready_s = 1'b1;
                end
            end
            SETUP: begin
                penable_s = 1'b1;
                state_s   = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    psel_s      = 1'b0;
                    penable_s   = 1'b0;
                    rsp_rdata_s = pwrite_r ? {DATA_W{1'b0}} : bus.prdata;
                    rsp_err_s   = bus.pslverr;
                    rsp_valid_s = 1'b1;
                    state_s     = RESP;
                end else if (timeout_hit_s) begin
                    psel_s      = 1'b0;
                    penable_s   = 1'b0;
                    rsp_rdata_s = {DATA_W{1'b0}};
                    rsp_err_s   = 1'b1;
                    rsp_valid_s = 1'b1;
                    state_s     = RESP;
                end else begin
                    state_s = ACCESS;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    cmd_ready_s = 1'b1;
                    state_s     = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s     = IDLE;
                cmd_ready_s = 1'b1;
                psel_s      = 1'b0;
                penable_s   = 1'b0;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops psel/penable immediately.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            paddr_r     <= {ADDR_W{1'b0}};
            pwdata_r    <= {DATA_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_s;
            cmd_ready_r <= cmd_ready_s;
            psel_r      <= psel_s;
            penable_r   <= penable_s;
            pwrite_r    <= pwrite_s;
            paddr_r     <= paddr_s;
            pwdata_r    <= pwdata_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_err_r   <= rsp_err_s;
            rsp_rdata_r <= rsp_rdata_s;
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.psel      = psel_r;
    assign bus.penable   = penable_r;
    assign bus.pwrite    = pwrite_r;
    assign bus.paddr     = paddr_r;
    assign bus.pwdata    = pwdata_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rsp_rdata_r;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: driver pushes expected responses, a monitor pops and compares.
module tb_apb_master_bridge;
    logic pclk;
    logic presetn;

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    int          n_vec;
    int          n_err;
    logic [32:0] exp_q[$];

    int          wait_cfg;
    int          wait_cnt;
    logic [31:0] rd_cfg;
    logic        err_cfg;
    logic        err_wait_cfg;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // APB slave model: wait_cfg ACCESS cycles with pready low, then completes.
    always @(negedge pclk) begin
        if (bus.psel && bus.penable) begin
            if (wait_cnt < wait_cfg) begin
                bus.pready  = 1'b0;
                bus.pslverr = err_wait_cfg;
                bus.prdata  = 32'hBAD0_BAD0;
                wait_cnt    = wait_cnt + 1;
            end else begin
                bus.pready  = 1'b1;
                bus.pslverr = err_cfg;
                bus.prdata  = rd_cfg;
            end
        end else begin
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
            wait_cnt    = 0;
        end
    end

    // Response monitor: compares each accepted response against the scoreboard.
    always @(negedge pclk) begin
        logic [32:0] e;
        #2;
        if (presetn && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", {32'd0, bus.rsp_rdata}, {32'd0, e[31:0]});
                chk("rsp_err", {63'd0, bus.rsp_err}, {63'd0, e[32]});
            end
        end
    end

    // Called one cycle after accept; returns cycle index at which rsp_valid is seen.
    task automatic wait_rsp(input logic [31:0] addr, input logic [31:0] wdata, output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 64) begin
            @(posedge pclk); #1;
            lat++;
            if (!bus.rsp_valid) begin
                chk("hold_psel", {63'd0, bus.psel}, 64'd1);
                chk("hold_penable", {63'd0, bus.penable}, 64'd1);
                chk("hold_paddr", {32'd0, bus.paddr}, {32'd0, addr});
                chk("hold_pwdata", {32'd0, bus.pwdata}, {32'd0, wdata});
            end
        end
    endtask

    task automatic xfer(input string nm, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rd, input logic err, input logic err_wait,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int lat;
        @(negedge pclk);
        wait_cfg      = waits;
        rd_cfg        = rd;
        err_cfg       = err;
        err_wait_cfg  = err_wait;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_valid = 1'b1;
        #1;
        chk({nm, "_cmd_ready"}, {63'd0, bus.cmd_ready}, 64'd1);
        @(posedge pclk); #1;
        bus.cmd_valid = 1'b0;
        exp_q.push_back({exp_err, exp_rd});
        chk({nm, "_setup_psel"}, {63'd0, bus.psel}, 64'd1);
        chk({nm, "_setup_penable"}, {63'd0, bus.penable}, 64'd0);
        chk({nm, "_pwrite"}, {63'd0, bus.pwrite}, {63'd0, wr});
        chk({nm, "_paddr"}, {32'd0, bus.paddr}, {32'd0, addr});
        chk({nm, "_pwdata"}, {32'd0, bus.pwdata}, {32'd0, wdata});
        chk({nm, "_busy"}, {63'd0, bus.cmd_ready}, 64'd0);
        wait_rsp(addr, wdata, lat);
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_done_psel"}, {62'd0, bus.psel, bus.penable}, 64'd0);
        @(posedge pclk); #1;
        chk({nm, "_idle_valid"}, {63'd0, bus.rsp_valid}, 64'd0);
        chk({nm, "_idle_ready"}, {63'd0, bus.cmd_ready}, 64'd1);
        chk({nm, "_paddr_kept"}, {32'd0, bus.paddr}, {32'd0, addr});
    endtask

    initial begin
        int lat;
        n_vec = 0;
        n_err = 0;
        wait_cfg = 0; rd_cfg = 32'd0; err_cfg = 1'b0; err_wait_cfg = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'd0; bus.cmd_wdata = 32'd0;
        bus.rsp_ready = 1'b1;
        bus.prdata = 32'd0; bus.pready = 1'b0; bus.pslverr = 1'b0;
        presetn = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        #1;
        chk("rst_apb_ctl", {61'd0, bus.psel, bus.penable, bus.pwrite}, 64'd0);
        chk("rst_paddr", {32'd0, bus.paddr}, 64'd0);
        chk("rst_pwdata", {32'd0, bus.pwdata}, 64'd0);
        chk("rst_rsp", {62'd0, bus.rsp_valid, bus.rsp_err}, 64'd0);
        chk("rst_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
        chk("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);

        xfer("wr0",    1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h1234_5678, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 3);
        xfer("rdwait", 1'b0, 32'h0000_0004, 32'h0000_0077, 3, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'hA5A5_5A5A, 1'b0, 6);
        xfer("errign", 1'b0, 32'h0000_0008, 32'h0000_0000, 2, 32'h1111_2222, 1'b0, 1'b1, 32'h1111_2222, 1'b0, 5);
        xfer("rderr",  1'b0, 32'h0000_000C, 32'h0000_0000, 0, 32'h3333_4444, 1'b1, 1'b0, 32'h3333_4444, 1'b1, 3);
        xfer("wrerr",  1'b1, 32'h0000_0100, 32'h0BAD_F00D, 1, 32'h9999_9999, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 4);

        // Response back-pressure with cmd_valid held high throughout.
        @(negedge pclk);
        bus.rsp_ready = 1'b0;
        wait_cfg = 0; rd_cfg = 32'h5555_AAAA; err_cfg = 1'b0; err_wait_cfg = 1'b0;
        bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0000_0020; bus.cmd_wdata = 32'h0000_0000;
        bus.cmd_valid = 1'b1;
        @(posedge pclk); #1;
        exp_q.push_back({1'b0, 32'h5555_AAAA});
        chk("bp_psel", {63'd0, bus.psel}, 64'd1);
        wait_rsp(32'h0000_0020, 32'h0000_0000, lat);
        chk("bp_latency", 64'(lat), 64'd3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
            chk("bp_rsp_rdata", {32'd0, bus.rsp_rdata}, {32'd0, 32'h5555_AAAA});
            chk("bp_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
            chk("bp_no_psel", {63'd0, bus.psel}, 64'd0);
            @(posedge pclk); #1;
        end
        rd_cfg = 32'h0F0F_0F0F;
        @(negedge pclk);
        bus.rsp_ready = 1'b1;
        @(posedge pclk); #1;
        chk("bp_released_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("bp_released_psel", {63'd0, bus.psel}, 64'd0);
        chk("bp_released_ready", {63'd0, bus.cmd_ready}, 64'd1);
        exp_q.push_back({1'b0, 32'h0F0F_0F0F});
        @(posedge pclk); #1;
        bus.cmd_valid = 1'b0;
        chk("bp_next_psel", {63'd0, bus.psel}, 64'd1);
        wait_rsp(32'h0000_0020, 32'h0000_0000, lat);
        chk("bp_next_latency", 64'(lat), 64'd3);
        @(posedge pclk); #1;
        chk("bp_next_idle", {63'd0, bus.cmd_ready}, 64'd1);

        // Reset asserted during ACCESS: no response may follow.
        @(negedge pclk);
        wait_cfg = 100; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0000_0030; bus.cmd_valid = 1'b1;
        @(posedge pclk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge pclk); #1;
        chk("mrst_in_access", {62'd0, bus.psel, bus.penable}, 64'd3);
        #2;
        presetn = 1'b0;
        #1;
        chk("mrst_apb_drop", {62'd0, bus.psel, bus.penable}, 64'd0);
        chk("mrst_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        @(negedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        wait_cfg = 0;
        #1;
        chk("mrst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge pclk); #1;
            chk("mrst_quiet", {62'd0, bus.rsp_valid, bus.psel}, 64'd0);
        end

`ifdef APB_MASTER_TIMEOUT_EN
        xfer("tmo", 1'b0, 32'h0000_0040, 32'h0000_0000, 1000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 6);
`else
        // Without the timeout the bridge must sit in ACCESS; recover with reset.
        @(negedge pclk);
        wait_cfg = 1000; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0000_0040; bus.cmd_valid = 1'b1;
        @(posedge pclk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge pclk); #1;
        for (int i = 0; i < 20; i++) begin
            chk("notmo_access", {61'd0, bus.psel, bus.penable, bus.rsp_valid}, 64'd6);
            @(posedge pclk); #1;
        end
        presetn = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        wait_cfg = 0;
        #1;
        chk("notmo_recover", {63'd0, bus.cmd_ready}, 64'd1);
`endif

        repeat (3) @(posedge pclk);
        #1;
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected $finish before 100000");
        $fatal(1, "watchdog expired");
    end
endmodule
